dp64_operand_packer: RTL and testbench

- Streaming producer for the 64-bit SIMD dot-product datapath (dp64): accepts one operand pair per cycle and packs pairs into 64-bit a/b lane vectors for the selected precision.
- Packed vectors are emitted with a valid/ready handshake, ready to drive dp64 inputs a and b.
- Unfilled lanes are zero, so a partial word contributes nothing to the dot product.

---
 rtl/dp64_operand_packer.sv | 172 +++++++++++++++++
 tb/tb_dp64_operand_packer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dp64_operand_packer.sv
// Packs one operand pair per cycle into zero-padded 64-bit a/b lane vectors for the dp64 datapath.
// Optional word counter output enabled by defining DP64_PACK_WORD_CNT_EN.
module dp64_operand_packer #(
   parameter int DATA_W = 64,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       in_a,
   input  logic [15:0]       in_b,
   input  logic [1:0]        in_mode,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic [1:0]        out_mode,
   output logic [5:0]        out_count,
   output logic              mode_err
`ifdef DP64_PACK_WORD_CNT_EN
   ,
   output logic [CNT_W-1:0]  word_cnt
`endif
);

   if (DATA_W != 64 || CNT_W < 1) begin : g_bad_param
      $error("dp64_operand_packer supports DATA_W=64 and CNT_W>=1 only");
   end

   typedef enum logic {S_FILL, S_HOLD} state_t;

   state_t            state_q;
   logic [4:0]        lane_q;
   logic [DATA_W-1:0] fill_a_q, fill_b_q;
   logic [1:0]        fill_mode_q;
   logic              out_valid_q;
   logic [DATA_W-1:0] out_a_q, out_b_q;
   logic [1:0]        out_mode_q;
   logic [5:0]        out_count_q;
   logic              mode_err_q;

   logic [1:0]        eff_mode;
   logic [DATA_W-1:0] lane_mask;
   logic [5:0]        shamt;
   logic [4:0]        last_lane;
   logic [DATA_W-1:0] fill_a_d, fill_b_d;
   logic [5:0]        count_d;
   logic              accept, complete, out_free, out_hs;

   // Mode is taken from the bus only on lane 0; later lanes follow the latched mode.
   assign eff_mode = (lane_q == 5'd0) ? in_mode : fill_mode_q;

   always_comb begin
      lane_mask = 64'h3;
      shamt     = {lane_q, 1'b0};
      last_lane = 5'd31;
      case (eff_mode)
         2'b00: begin
            lane_mask = 64'hFFFF;
            shamt     = {lane_q[1:0], 4'b0000};
            last_lane = 5'd3;
         end
         2'b01: begin
            lane_mask = 64'hFF;
            shamt     = {lane_q[2:0], 3'b000};
            last_lane = 5'd7;
         end
         2'b10: begin
            lane_mask = 64'hF;
            shamt     = {lane_q[3:0], 2'b00};
            last_lane = 5'd15;
         end
         default: begin
            lane_mask = 64'h3;
            shamt     = {lane_q, 1'b0};
            last_lane = 5'd31;
         end
      endcase
   end

   assign fill_a_d = fill_a_q | (({48'b0, in_a} & lane_mask) << shamt);
   assign fill_b_d = fill_b_q | (({48'b0, in_b} & lane_mask) << shamt);
   assign count_d  = {1'b0, lane_q} + 6'd1;

   assign in_ready = (state_q == S_FILL);
   assign accept   = in_valid && in_ready;
   assign complete = accept && (in_last || lane_q == last_lane);
   assign out_hs   = out_valid_q && out_ready;
   assign out_free = !out_valid_q || out_ready;

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state_q     <= S_FILL;
         lane_q      <= 5'd0;
         fill_a_q    <= '0;
         fill_b_q    <= '0;
         fill_mode_q <= 2'b00;
         out_valid_q <= 1'b0;
         out_a_q     <= '0;
         out_b_q     <= '0;
         out_mode_q  <= 2'b00;
         out_count_q <= 6'd0;
         mode_err_q  <= 1'b0;
      end else begin
         if (out_hs)
            out_valid_q <= 1'b0;
         if (accept && lane_q != 5'd0 && in_mode != fill_mode_q)
            mode_err_q <= 1'b1;
         case (state_q)
            S_FILL: begin
               if (accept) begin
                  if (complete && out_free) begin
                     out_valid_q <= 1'b1;
                     out_a_q     <= fill_a_d;
                     out_b_q     <= fill_b_d;
                     out_mode_q  <= eff_mode;
                     out_count_q <= count_d;
                     fill_a_q    <= '0;
                     fill_b_q    <= '0;
                     lane_q      <= 5'd0;
                  end else begin
                     fill_a_q    <= fill_a_d;
                     fill_b_q    <= fill_b_d;
                     fill_mode_q <= eff_mode;
                     // lane_q is kept on the final lane so HOLD can derive the count
                     if (complete)
                        state_q <= S_HOLD;
                     else
                        lane_q <= lane_q + 5'd1;
                  end
               end
            end
            S_HOLD: begin
               if (out_hs) begin
                  out_valid_q <= 1'b1;
                  out_a_q     <= fill_a_q;
                  out_b_q     <= fill_b_q;
                  out_mode_q  <= fill_mode_q;
                  out_count_q <= count_d;
                  fill_a_q    <= '0;
                  fill_b_q    <= '0;
                  lane_q      <= 5'd0;
                  state_q     <= S_FILL;
               end
            end
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_a     = out_a_q;
   assign out_b     = out_b_q;
   assign out_mode  = out_mode_q;
   assign out_count = out_count_q;
   assign mode_err  = mode_err_q;

`ifdef DP64_PACK_WORD_CNT_EN
   logic [CNT_W-1:0] word_cnt_q;

   always_ff @(posedge CLK or posedge rst) begin
      if (rst)
         word_cnt_q <= '0;
      else if (out_hs)
         word_cnt_q <= word_cnt_q + CNT_W'(1);
   end

   assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_dp64_operand_packer.sv
// Directed-vector bench for dp64_operand_packer with hand-computed expected words.
module tb_dp64_operand_packer;

   logic        CLK = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [15:0] in_a, in_b;
   logic [1:0]  in_mode;
   logic        in_last;
   logic        out_valid, out_ready;
   logic [63:0] out_a, out_b;
   logic [1:0]  out_mode;
   logic [5:0]  out_count;
   logic        mode_err;
`ifdef DP64_PACK_WORD_CNT_EN
   logic [15:0] word_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   dp64_operand_packer dut (
      .CLK       (CLK),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_mode   (in_mode),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_mode  (out_mode),
      .out_count (out_count),
      .mode_err  (mode_err)
`ifdef DP64_PACK_WORD_CNT_EN
      ,
      .word_cnt  (word_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic push(input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] mode, input logic last);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_mode  = mode;
      in_last  = last;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   function automatic logic [63:0] word16(input int base, input int off);
      logic [63:0] w;
      w = '0;
      for (int l = 0; l < 4; l++)
         w[l*16 +: 16] = 16'(off + base + l);
      return w;
   endfunction

   initial begin
      int k, widx;
      logic acc;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_mode   = 2'b00;
      in_last   = 1'b0;
      out_ready = 1'b0;
      rst       = 1'b1;
      #12;
      rst = 1'b0;
      #1;

      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_a", out_a, 64'd0);
      check("rst_out_count", 64'(out_count), 64'd0);
      check("rst_mode_err", 64'(mode_err), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // int16 full word
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check("i16_in_ready", 64'(in_ready), 64'd1);
         push(16'(i), 16'(i), 2'b00, 1'b0);
      end
      check("i16_valid", 64'(out_valid), 64'd1);
      check("i16_a", out_a, 64'h0004_0003_0002_0001);
      check("i16_b", out_b, 64'h0004_0003_0002_0001);
      check("i16_count", 64'(out_count), 64'd4);
      check("i16_mode", 64'(out_mode), 64'd0);
      step();
      check("i16_drained", 64'(out_valid), 64'd0);

      // int2 full word, upper input bits discarded
      for (int i = 0; i < 32; i++)
         push(16'hFFFD, 16'h0003, 2'b11, 1'b0);
      check("i2_valid", 64'(out_valid), 64'd1);
      check("i2_a", out_a, 64'h5555_5555_5555_5555);
      check("i2_b", out_b, 64'hFFFF_FFFF_FFFF_FFFF);
      check("i2_count", 64'(out_count), 64'd32);
      check("i2_mode", 64'(out_mode), 64'd3);
      step();

      // int8 partial word
      push(16'h00FF, 16'h0001, 2'b01, 1'b0);
      push(16'h00FF, 16'h0001, 2'b01, 1'b0);
      push(16'h00FF, 16'h0001, 2'b01, 1'b1);
      check("i8_valid", 64'(out_valid), 64'd1);
      check("i8_a", out_a, 64'h0000_0000_00FF_FFFF);
      check("i8_b", out_b, 64'h0000_0000_0001_0101);
      check("i8_count", 64'(out_count), 64'd3);
      check("i8_mode", 64'(out_mode), 64'd1);
      step();
      check("i8_drained", 64'(out_valid), 64'd0);

      // backpressure: 12 int16 pairs, a=k, b=0x100+k
      out_ready = 1'b0;
      k    = 1;
      widx = 0;
      for (int cyc = 0; cyc < 60 && widx < 3; cyc++) begin
         if (cyc == 12) begin
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
            check("bp_accepted", 64'(k), 64'd9);
            check("bp_held_valid", 64'(out_valid), 64'd1);
            check("bp_held_a", out_a, word16(1, 0));
            out_ready = 1'b1;
         end
         in_valid = (k <= 12);
         in_a     = 16'(k);
         in_b     = 16'(k + 16'h100);
         in_mode  = 2'b00;
         acc      = in_valid && in_ready;
         if (out_valid && out_ready) begin
            check("bp_word_a", out_a, word16(1 + 4*widx, 0));
            check("bp_word_b", out_b, word16(1 + 4*widx, 16'h100));
            widx++;
         end
         step();
         if (acc)
            k++;
      end
      in_valid = 1'b0;
      check("bp_word_total", 64'(widx), 64'd3);
      check("bp_no_dup", 64'(out_valid), 64'd0);

      // mode change mid-word: packed under latched int8
      push(16'h0011, 16'h0022, 2'b01, 1'b0);
      check("mc_err_before", 64'(mode_err), 64'd0);
      push(16'h0033, 16'h0044, 2'b10, 1'b0);
      check("mc_err_set", 64'(mode_err), 64'd1);
      push(16'h0055, 16'h0066, 2'b01, 1'b1);
      check("mc_a", out_a, 64'h0000_0000_0055_3311);
      check("mc_b", out_b, 64'h0000_0000_0066_4422);
      check("mc_mode", 64'(out_mode), 64'd1);
      check("mc_count", 64'(out_count), 64'd3);
      push(16'h0007, 16'h0008, 2'b00, 1'b1);
      check("mc_l0_a", out_a, 64'h7);
      check("mc_l0_count", 64'(out_count), 64'd1);
      check("mc_err_sticky", 64'(mode_err), 64'd1);
      step();

      // reset mid-word
      push(16'h0009, 16'h0009, 2'b00, 1'b0);
      push(16'h000A, 16'h000A, 2'b00, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("mr_out_a", out_a, 64'd0);
      check("mr_mode_err", 64'(mode_err), 64'd0);
      check("mr_out_count", 64'(out_count), 64'd0);
      check("mr_in_ready", 64'(in_ready), 64'd1);
      @(negedge CLK);
      rst = 1'b0;
      step();
      in_last = 1'b1;
      step();
      in_last = 1'b0;
      check("idle_last_ignored", 64'(out_valid), 64'd0);
      for (int i = 0; i < 4; i++)
         push(16'(16'h21 + i), 16'(16'h31 + i), 2'b00, 1'b0);
      check("mr_valid", 64'(out_valid), 64'd1);
      check("mr_a", out_a, 64'h0024_0023_0022_0021);
      check("mr_b", out_b, 64'h0034_0033_0032_0031);
      check("mr_count", 64'(out_count), 64'd4);
      step();
`ifdef DP64_PACK_WORD_CNT_EN
      check("word_cnt", 64'(word_cnt), 64'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
